// File: rtl/t07_mem_pkg.sv
// t07 memory arbiter shared package.
// FSM states, bus rwi codes and arbitration modes.
package t07_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

  localparam logic [1:0] RWI_IDLE  = 2'b00;
  localparam logic [1:0] RWI_READ  = 2'b01;
  localparam logic [1:0] RWI_WRITE = 2'b10;
  localparam logic [1:0] RWI_FETCH = 2'b11;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // A write always encodes as a write, even on the fetch channel.
  function automatic logic [1:0] rwi_code(
    input logic wr,
    input logic fetch
  );
    if (wr)
      return RWI_WRITE;
    else if (fetch)
      return RWI_FETCH;
    else
      return RWI_READ;
  endfunction

endpackage

// File: rtl/t07_rr_arbiter.sv
// t07 channel arbiter: combinational winner, fixed or round-robin.
// Ports: clk, nrst (sync, active-high), req, grant_en in; any, grant, win out.
module t07_rr_arbiter
  import t07_mem_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      grant_en,
  output logic                      any,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] win
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] idx;

  // Fixed: scan upward from ch0. RR: scan from rr_ptr+1, wrapping.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == ARB_RR)
        idx = CH_W'((int'(rr_ptr) + 1 + i) % NUM_CH);
      else
        idx = CH_W'(i);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (any)
      grant[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (nrst)
      rr_ptr <= '0;
    else if (grant_en)
      rr_ptr <= win;
  end

endmodule

// File: rtl/t07_mem_arbiter.sv
// t07 multi-channel memory arbiter with busy handshake and timeout.
// Ports: per-channel req/rsp, shared ext bus, rwi_o, freeze_o, busy_edge_o.
module t07_mem_arbiter
  import t07_mem_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ARB_MODE    = 0,
  parameter int FETCH_CH    = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH-1:0]        req_write_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic [NUM_CH-1:0]        rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [DATA_W-1:0]        rsp_rdata_o,
  output logic [ADDR_W-1:0]        ext_addr_o,
  output logic [DATA_W-1:0]        ext_wdata_o,
  input  logic [DATA_W-1:0]        ext_rdata_i,
  input  logic                     ext_busy_i,
  output logic [1:0]               rwi_o,
  output logic                     freeze_o,
  output logic                     busy_edge_o
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYC - 1);
  localparam logic [CH_W-1:0] F_CH = CH_W'(FETCH_CH);

  mem_state_t state, state_nx;

  logic [ADDR_W-1:0] addr_arr [NUM_CH];
  logic [DATA_W-1:0] wdat_arr [NUM_CH];

  logic [CH_W-1:0]   ch_q;
  logic [TW-1:0]     tmo_cnt;
  logic              busy_prev;
  logic              err_q;
  logic              any;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   win;
  logic              grant_en;
  logic              fall;
  logic              expire;
  logic              active;
  logic              done;
  logic              tmo;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
    assign wdat_arr[k] = req_wdata_i[k*DATA_W +: DATA_W];
  end

  // No grant while reset is held, so no request is dropped.
  assign grant_en = (state == IDLE) & any & ~nrst;

  assign fall        = busy_prev & ~ext_busy_i;
  assign busy_edge_o = fall;
  assign active      = (state == ISSUE) | (state == WAIT);
  assign expire      = tmo_cnt == T_LAST;
  // Completion beats expiry when both land on one cycle.
  assign done        = (state == WAIT) & fall;
  assign tmo         = active & expire & ~done;

  t07_rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .nrst     (nrst),
    .req      (req_valid_i),
    .grant_en (grant_en),
    .any      (any),
    .grant    (grant),
    .win      (win)
  );

  always_ff @(posedge clk) begin
    if (nrst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (grant_en) state_nx = ISSUE;
      ISSUE: begin
        if (expire)
          state_nx = RESP;
        else if (ext_busy_i)
          state_nx = WAIT;
      end
      WAIT:  if (fall || expire) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    freeze_o    = 1'b0;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_err_o   = 1'b0;
    unique case (state)
      IDLE:  if (!nrst) req_ready_o = grant;
      ISSUE, WAIT: freeze_o = 1'b1;
      RESP: begin
        rsp_valid_o[ch_q] = 1'b1;
        rsp_err_o         = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      ch_q        <= '0;
      ext_addr_o  <= '0;
      ext_wdata_o <= '0;
      rwi_o       <= RWI_IDLE;
      rsp_rdata_o <= '0;
      err_q       <= 1'b0;
    end else if (grant_en) begin
      ch_q        <= win;
      ext_addr_o  <= addr_arr[win];
      ext_wdata_o <= wdat_arr[win];
      rwi_o       <= rwi_code(req_write_i[win],
                              win == F_CH);
    end else if (done) begin
      rsp_rdata_o <= ext_rdata_i;
      rwi_o       <= RWI_IDLE;
      err_q       <= 1'b0;
    end else if (tmo) begin
      rsp_rdata_o <= '0;
      rwi_o       <= RWI_IDLE;
      err_q       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst)
      tmo_cnt <= '0;
    else if (active)
      tmo_cnt <= tmo_cnt + TW'(1);
    else
      tmo_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (nrst)
      busy_prev <= 1'b0;
    else
      busy_prev <= ext_busy_i;
  end

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// t07 memory arbiter bench: fixed-priority and round-robin instances.
// Directed plan cases plus randomized traffic against a transaction model.
module tb_t07_mem_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int FCH = 0;

  logic clk = 1'b0;
  logic nrst = 1'b1;

  logic [N-1:0]    req_valid [2];
  logic [N-1:0]    req_write [2];
  logic [N*AW-1:0] req_addr  [2];
  logic [N*DW-1:0] req_wdata [2];
  logic [N-1:0]    req_ready [2];
  logic [N-1:0]    rsp_valid [2];
  logic            rsp_err   [2];
  logic [DW-1:0]   rsp_rdata [2];
  logic [AW-1:0]   ext_addr  [2];
  logic [DW-1:0]   ext_wdata [2];
  logic [DW-1:0]   ext_rdata [2];
  logic            ext_busy  [2];
  logic [1:0]      rwi       [2];
  logic            freeze    [2];
  logic            busy_edge [2];

  bit            pv [2][N];
  bit            pw [2][N];
  logic [AW-1:0] pa [2][N];
  logic [DW-1:0] pd [2][N];
  int            last [2];
  logic          bprev [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  t07_mem_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .ARB_MODE(0), .FETCH_CH(FCH),
    .TIMEOUT_CYC(TO)
  ) u_fix (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid[0]),
    .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]),
    .req_ready_o(req_ready[0]),
    .rsp_valid_o(rsp_valid[0]),
    .rsp_err_o(rsp_err[0]),
    .rsp_rdata_o(rsp_rdata[0]),
    .ext_addr_o(ext_addr[0]),
    .ext_wdata_o(ext_wdata[0]),
    .ext_rdata_i(ext_rdata[0]),
    .ext_busy_i(ext_busy[0]),
    .rwi_o(rwi[0]),
    .freeze_o(freeze[0]),
    .busy_edge_o(busy_edge[0])
  );

  t07_mem_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW),
    .ARB_MODE(1), .FETCH_CH(FCH),
    .TIMEOUT_CYC(TO)
  ) u_rr (
    .clk(clk), .nrst(nrst),
    .req_valid_i(req_valid[1]),
    .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]),
    .req_ready_o(req_ready[1]),
    .rsp_valid_o(rsp_valid[1]),
    .rsp_err_o(rsp_err[1]),
    .rsp_rdata_o(rsp_rdata[1]),
    .ext_addr_o(ext_addr[1]),
    .ext_wdata_o(ext_wdata[1]),
    .ext_rdata_i(ext_rdata[1]),
    .ext_busy_i(ext_busy[1]),
    .rwi_o(rwi[1]),
    .freeze_o(freeze[1]),
    .busy_edge_o(busy_edge[1])
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++)
      bprev[d] = nrst ? 1'b0 : ext_busy[d];
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input int d);
    for (int ch = 0; ch < N; ch++) begin
      req_valid[d][ch] = pv[d][ch];
      req_write[d][ch] = pw[d][ch];
      req_addr[d][ch*AW +: AW]  = pa[d][ch];
      req_wdata[d][ch*DW +: DW] = pd[d][ch];
    end
  endtask

  task automatic set_req(input int d, input int ch,
                         input bit wr,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    pv[d][ch] = 1'b1;
    pw[d][ch] = wr;
    pa[d][ch] = a;
    pd[d][ch] = wd;
  endtask

  task automatic clear_req(input int d);
    for (int ch = 0; ch < N; ch++) pv[d][ch] = 1'b0;
    drive_req(d);
  endtask

  task automatic add_rand(input int d);
    int ch;
    ch = int'($urandom_range(0, N - 1));
    if (!pv[d][ch])
      set_req(d, ch, bit'($urandom_range(0, 1)),
              $urandom, $urandom);
  endtask

  // d0 = fixed priority, d1 = round robin from last winner.
  function automatic int pick(input int d);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (d == 0) ? i : (last[d] + 1 + i) % N;
      if (pv[d][k]) return k;
    end
    return -1;
  endfunction

  // One transaction from its IDLE cycle through RESP.
  // Busy rises d1 cycles into ISSUE (d1<0: never) for blen cycles.
  task automatic run_xact(input int d, input int d1,
                          input int blen,
                          input logic [DW-1:0] rd,
                          input bit arrive,
                          output int g);
    int w, f, rc;
    bit ok;
    logic [1:0] code;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    tick();
    drive_req(d);
    sample();
    w = pick(d);
    g = -1;
    for (int i = 0; i < N; i++)
      if (req_ready[d][i]) g = i;
    if (w < 0) begin
      chk("ready_none", 64'(req_ready[d]), 64'(0));
      return;
    end
    chk("ready", 64'(req_ready[d]), 64'(1) << w);
    chk("idle_frz", 64'(freeze[d]), 64'(0));
    chk("idle_rwi", 64'(rwi[d]), 64'(0));
    chk("idle_rsp", 64'(rsp_valid[d]), 64'(0));
    a  = pa[d][w];
    wd = pd[d][w];
    if (pw[d][w]) code = 2'b10;
    else if (w == FCH) code = 2'b11;
    else code = 2'b01;
    last[d]  = w;
    pv[d][w] = 1'b0;
    f  = (d1 < 0) ? 1000 : 1 + d1 + blen;
    ok = (f <= TO);
    rc = ok ? f + 1 : TO + 1;
    for (int c = 1; c <= rc; c++) begin
      tick();
      ext_busy[d] = (c < rc) && (d1 >= 0) &&
                    (c >= 1 + d1) && (c < f);
      ext_rdata[d] = (c == f) ? rd : $urandom;
      if (arrive && $urandom_range(0, 3) == 0)
        add_rand(d);
      drive_req(d);
      sample();
      chk("edge", 64'(busy_edge[d]),
          64'(bprev[d] & ~ext_busy[d]));
      chk("ready_busy", 64'(req_ready[d]), 64'(0));
      if (c < rc) begin
        chk("frz", 64'(freeze[d]), 64'(1));
        chk("rwi", 64'(rwi[d]), 64'(code));
        chk("addr", 64'(ext_addr[d]), 64'(a));
        chk("wdata", 64'(ext_wdata[d]), 64'(wd));
        chk("rsp_early", 64'(rsp_valid[d]), 64'(0));
      end else begin
        chk("rsp", 64'(rsp_valid[d]), 64'(1) << w);
        chk("err", 64'(rsp_err[d]), 64'(!ok));
        chk("rdata", 64'(rsp_rdata[d]),
            ok ? 64'(rd) : 64'(0));
        chk("resp_rwi", 64'(rwi[d]), 64'(0));
        chk("resp_frz", 64'(freeze[d]), 64'(0));
      end
    end
  endtask

  int exp_rr [6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    int g;
    int d1;
    bool_init();
    repeat (3) tick();
    sample();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 64'(req_ready[d]), 64'(0));
      chk("rst_rsp", 64'(rsp_valid[d]), 64'(0));
      chk("rst_err", 64'(rsp_err[d]), 64'(0));
      chk("rst_rdata", 64'(rsp_rdata[d]), 64'(0));
      chk("rst_addr", 64'(ext_addr[d]), 64'(0));
      chk("rst_wdata", 64'(ext_wdata[d]), 64'(0));
      chk("rst_rwi", 64'(rwi[d]), 64'(0));
      chk("rst_frz", 64'(freeze[d]), 64'(0));
      chk("rst_edge", 64'(busy_edge[d]), 64'(0));
    end
    tick();
    nrst = 1'b0;

    // Single read: busy 2..4, falls at 5, RESP at 6.
    set_req(0, 1, 1'b0, 32'h0000_1000, 32'h0);
    run_xact(0, 1, 3, 32'hDEAD_BEEF, 1'b0, g);

    // Fixed priority: ch0 fetch first, ch2 write next.
    set_req(0, 0, 1'b0, 32'h0000_0040, 32'h0);
    set_req(0, 2, 1'b1, 32'h0000_2000, 32'h1234);
    run_xact(0, 0, 2, 32'h1111_2222, 1'b0, g);
    chk("fp_first", 64'(g), 64'(0));
    run_xact(0, 0, 2, 32'h3333_4444, 1'b0, g);
    chk("fp_second", 64'(g), 64'(2));

    // Timeout with busy never raised.
    set_req(0, 1, 1'b0, 32'h0000_5000, 32'h0);
    run_xact(0, -1, 1, 32'h0, 1'b0, g);

    // Busy falls exactly on the expiry cycle.
    set_req(0, 2, 1'b0, 32'h0000_6000, 32'h0);
    run_xact(0, 2, TO - 3, 32'hCAFE_F00D, 1'b0, g);

    // Round robin with all channels requesting.
    for (int i = 0; i < 6; i++) begin
      for (int ch = 0; ch < N; ch++)
        if (!pv[1][ch])
          set_req(1, ch, bit'($urandom_range(0, 1)),
                  $urandom, $urandom);
      run_xact(1, 0, 2, $urandom, 1'b0, g);
      chk("rr_order", 64'(g), 64'(exp_rr[i]));
    end
    clear_req(1);

    // Reset in WAIT aborts with no response pulse.
    set_req(0, 1, 1'b0, 32'h0000_3000, 32'h0);
    tick();
    drive_req(0);
    sample();
    chk("mid_ready", 64'(req_ready[0]), 64'(2));
    pv[0][1] = 1'b0;
    tick();
    drive_req(0);
    sample();
    chk("mid_rwi", 64'(rwi[0]), 64'(1));
    tick();
    ext_busy[0] = 1'b1;
    sample();
    tick();
    sample();
    chk("mid_frz", 64'(freeze[0]), 64'(1));
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    ext_busy[0] = 1'b0;
    sample();
    chk("abort_rwi", 64'(rwi[0]), 64'(0));
    chk("abort_frz", 64'(freeze[0]), 64'(0));
    chk("abort_rsp", 64'(rsp_valid[0]), 64'(0));
    chk("abort_addr", 64'(ext_addr[0]), 64'(0));
    chk("abort_edge", 64'(busy_edge[0]), 64'(0));
    last[0] = 0;
    last[1] = 0;
    tick();
    sample();
    chk("abort_rsp2", 64'(rsp_valid[0]), 64'(0));
    chk("abort_frz2", 64'(freeze[0]), 64'(0));

    // Randomized traffic on each instance in turn.
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 120; it++) begin
        for (int ch = 0; ch < N; ch++)
          if (!pv[d][ch] && $urandom_range(0, 2) != 0)
            set_req(d, ch, bit'($urandom_range(0, 1)),
                    $urandom, $urandom);
        if (pick(d) < 0) begin
          tick();
          drive_req(d);
          sample();
          chk("empty_ready", 64'(req_ready[d]), 64'(0));
          chk("empty_frz", 64'(freeze[d]), 64'(0));
        end else begin
          d1 = ($urandom_range(0, 7) == 0) ? -1
               : int'($urandom_range(0, 3));
          run_xact(d, d1, int'($urandom_range(1, 6)),
                   $urandom, 1'b1, g);
        end
      end
      clear_req(d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  task automatic bool_init();
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_write[d] = '0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      ext_rdata[d] = '0;
      ext_busy[d]  = 1'b0;
      last[d]      = 0;
      bprev[d]     = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        pv[d][ch] = 1'b0;
        pw[d][ch] = 1'b0;
        pa[d][ch] = '0;
        pd[d][ch] = '0;
      end
    end
  endtask

endmodule

// File: doc/t07_mem_arbiter.md
Name: t07_mem_arbiter

Overview:
- Parametrised multi-channel memory arbiter for the t07 core. Generalises the single fetch/load-store memory handler to NUM_CH requesters (e.g. fetch, load/store, FPU) sharing one external memory bus with a busy handshake.
- Arbitration is selectable: fixed priority or round-robin.
- Adds a per-transaction timeout with an error response.
- Generates the bus rwi encoding and the core freeze signal.

Parameters:
- NUM_CH, 3, number of requester channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (ch0 highest), 1 = round-robin.
- FETCH_CH, 0, channel whose reads are encoded as instruction fetches.
- TIMEOUT_CYC, 64, cycles allowed in ISSUE+WAIT before error.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset; synchronous, active-high (1 = reset).
- req_valid_i  in  NUM_CH  per-channel request.
- req_write_i  in  NUM_CH  per-channel 1 = write, 0 = read.
- req_addr_i  in  NUM_CH*ADDR_W  packed addresses; ch k at bits [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_CH*DATA_W  packed write data.
- req_ready_o  out  NUM_CH  one-hot grant/accept.
- rsp_valid_o  out  NUM_CH  one-hot completion pulse.
- rsp_err_o  out  1  completion was a timeout.
- rsp_rdata_o  out  DATA_W  read data, shared by all channels.
- ext_addr_o  out  ADDR_W  bus address.
- ext_wdata_o  out  DATA_W  bus write data.
- ext_rdata_i  in  DATA_W  bus read data.
- ext_busy_i  in  1  memory busy.
- rwi_o  out  2  bus command.
- freeze_o  out  1  stall the core.
- busy_edge_o  out  1  ext_busy_i falling-edge pulse.

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0.
  - rr_ptr = 0; timeout counter = 0; busy_prev = 0.
  - Reset mid-transaction aborts it with no rsp_valid pulse.
- rwi encoding:
  - 00 idle.
  - 01 data read.
  - 10 write.
  - 11 fetch (read on FETCH_CH; a write on FETCH_CH uses 10).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, the winner w is chosen combinationally and req_ready_o[w] = 1 in the same cycle.
  - Channel index, addr, wdata and write bit are latched at the clock edge; go to ISSUE.
  - No request: stay in IDLE.
- Arbitration:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starts at rr_ptr+1 modulo NUM_CH, wrapping; rr_ptr <= w on grant.
  - A single requester always wins in both modes.
- ISSUE:
  - ext_addr_o, ext_wdata_o and rwi_o are driven from the latch (registered outputs).
  - Go to WAIT on the first cycle ext_busy_i = 1.
- WAIT:
  - Hold all bus outputs.
  - On the falling edge (busy_prev = 1 and ext_busy_i = 0): latch ext_rdata_i into rsp_rdata_o (writes latch it too), clear rwi_o to 00, go to RESP.
- RESP:
  - rsp_valid_o[w] = 1 for exactly one cycle, rsp_err_o = 0.
  - Go to IDLE; a new grant is possible in the next cycle.
  - Minimum turnaround: grant at cycle 0, ISSUE at 1, busy seen at 2, fall at n, RESP at n+1.
- Timeout:
  - The counter increments in ISSUE and WAIT and clears in IDLE.
  - When it reaches TIMEOUT_CYC-1 without completion: go to RESP with rsp_err_o = 1, rsp_rdata_o = 0, rwi_o = 00.
  - A busy fall in the same cycle as expiry counts as success (completion has priority).
- busy_edge_o = busy_prev & ~ext_busy_i, in every state; busy_prev is registered every cycle.
- freeze_o = 1 in ISSUE and WAIT; 0 in IDLE and RESP. It does not depend combinationally on req_valid_i.
- Requests changing while not granted are ignored; a requester must hold req_valid_i until req_ready_o.
- Requests arriving during RESP wait until IDLE.

Decomposition:
- Shared package t07_mem_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - rwi constants RWI_IDLE / RWI_READ / RWI_WRITE / RWI_FETCH.
  - ARB_FIXED / ARB_RR constants.
- One sub-module, t07_rr_arbiter: parametrised NUM_CH/ARB_MODE, combinational winner from req vector and rr_ptr, with grant-enable pointer update. The FSM, latch and timeout stay in t07_mem_arbiter.

Test Plan:
- Single read: ch1 reads 0x0000_1000; memory raises busy at cycle 2 and drops it at cycle 5 with rdata 0xDEAD_BEEF → rwi_o = 01 during cycles 1–5; rsp_valid_o = 010 and rsp_rdata_o = 0xDEAD_BEEF at cycle 6; freeze_o high only in cycles 1–5.
- Fixed priority: ARB_MODE = 0, ch0 fetch (0x0000_0040) and ch2 write (0x2000, 0x1234) requested together → ch0 is granted first with rwi_o = 11; ch2 is granted in the IDLE after ch0's RESP with rwi_o = 10 and ext_wdata_o = 0x1234.
- Round-robin fairness: ARB_MODE = 1, all 3 channels request continuously for 6 transactions → grant order 1, 2, 0, 1, 2, 0.
- Timeout: TIMEOUT_CYC = 8, busy never asserted → RESP at cycle 9 with rsp_err_o = 1 and rsp_rdata_o = 0; rwi_o = 00 from cycle 9.
- Reset mid-op: assert nrst = 1 in WAIT → next cycle state IDLE, rwi_o = 00, freeze_o = 0, no rsp_valid_o pulse.
- Completion vs expiry tie: busy falls exactly on the expiry cycle → rsp_err_o = 0 and data is returned.
